// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a variable-latency instruction memory and
// fills the IF/ID register, handling decode stalls and branch redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h01000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] inst_d,
  output logic [31:0] pc_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_vld_q, ifid_vld_d;

  logic [31:0] redir_tgt;
  logic        unused_redir_lsb;

  assign redir_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  // HOLD parks the fetched word, so no new request is issued until decode drains it
  assign imem_req  = reset_n && (state_q != HOLD);
  assign imem_addr = {fetch_pc_q[31:2], 2'b00};

  assign inst_d  = ifid_inst_q;
  assign pc_d    = ifid_pc_q;
  assign valid_d = ifid_vld_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_pc_d   = pend_pc_q;
    hold_inst_d = hold_inst_q;
    ifid_inst_d = ifid_inst_q;
    ifid_pc_d   = ifid_pc_q;
    ifid_vld_d  = ifid_vld_q;

    if (redirect) begin
      // Redirect outranks stall and ack: the slot becomes a bubble right away
      ifid_inst_d = NOP_INST;
      ifid_vld_d  = 1'b0;
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            fetch_pc_d = redir_tgt;
          end else begin
            // Address must stay put until the in-flight word returns
            pend_pc_d = redir_tgt;
            state_d   = DISCARD;
          end
        end
        HOLD: begin
          fetch_pc_d  = redir_tgt;
          hold_inst_d = NOP_INST;
          state_d     = FETCH;
        end
        DISCARD: begin
          if (imem_ack) begin
            fetch_pc_d = redir_tgt;
            state_d    = FETCH;
          end else begin
            pend_pc_d = redir_tgt;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (stall) begin
              hold_inst_d = imem_data;
              state_d     = HOLD;
            end else begin
              ifid_inst_d = imem_data;
              ifid_pc_d   = fetch_pc_q;
              ifid_vld_d  = 1'b1;
            end
          end else if (!stall) begin
            ifid_inst_d = NOP_INST;
            ifid_pc_d   = fetch_pc_q;
            ifid_vld_d  = 1'b0;
          end
        end
        HOLD: begin
          // fetch_pc already points past the parked word
          if (!stall) begin
            ifid_inst_d = hold_inst_q;
            ifid_pc_d   = fetch_pc_q - 32'd4;
            ifid_vld_d  = 1'b1;
            state_d     = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            fetch_pc_d = pend_pc_q;
            state_d    = FETCH;
          end
          if (!stall) begin
            ifid_inst_d = NOP_INST;
            ifid_pc_d   = fetch_pc_q;
            ifid_vld_d  = 1'b0;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      pend_pc_q   <= 32'd0;
      hold_inst_q <= NOP_INST;
      ifid_inst_q <= NOP_INST;
      ifid_pc_q   <= 32'd0;
      ifid_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      hold_inst_q <= hold_inst_d;
      ifid_inst_q <= ifid_inst_d;
      ifid_pc_q   <= ifid_pc_d;
      ifid_vld_q  <= ifid_vld_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Random stall/redirect/latency bench for fetch_stage; a scoreboard holds the
// expected program-order instruction stream and a monitor checks each delivery.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h01000000;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst_d;
  logic [31:0] pc_d;
  logic        valid_d;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst_d(inst_d),
    .pc_d(pc_d), .valid_d(valid_d)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails = 0;
  int delivered = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] next_push_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E69;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: next_push_pc, inst: mem_word(next_push_pc)});
      next_push_pc = next_push_pc + 32'd4;
    end
  endtask

  // Sequential program order from a new start address; older words never appear again
  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    next_push_pc = {start[31:2], 2'b00};
    top_up();
  endtask

  // Memory model: random 1..4 cycle latency, data is a function of address
  logic        outstanding = 1'b0;
  logic        drove_req = 1'b0;
  logic [31:0] saved_addr = 32'd0;
  int          lat = 0;
  always @(negedge clock) begin
    if (!reset_n) begin
      imem_ack    = 1'b0;
      outstanding = 1'b0;
      drove_req   = 1'b0;
    end else begin
      if (imem_ack && drove_req) outstanding = 1'b0;
      drove_req = imem_req;
      if (imem_req) begin
        if (!outstanding) begin
          outstanding = 1'b1;
          saved_addr  = imem_addr;
          lat         = $urandom_range(0, 3);
        end else begin
          check("addr_stable", imem_addr, saved_addr);
        end
        if (lat == 0) begin
          imem_ack  = 1'b1;
          imem_data = mem_word(imem_addr);
        end else begin
          lat       = lat - 1;
          imem_ack  = 1'b0;
          imem_data = $urandom;
        end
      end else begin
        // Stray acks while no request is pending must be ignored
        imem_ack  = ($urandom_range(0, 3) == 0);
        imem_data = $urandom;
      end
    end
  end

  // Monitor
  logic [31:0] prev_inst = NOP;
  logic [31:0] prev_pc = 32'd0;
  logic        prev_vld = 1'b0;
  always @(posedge clock) begin
    logic adv, was_redir, rst_seen;
    exp_t e;
    adv       = !stall || redirect;
    was_redir = redirect;
    rst_seen  = !reset_n;
    #1;
    if (rst_seen || !reset_n) begin
      prev_inst = NOP;
      prev_pc   = 32'd0;
      prev_vld  = 1'b0;
    end else begin
      if (was_redir) check("redirect_bubble_valid", {31'd0, valid_d}, 32'd0);
      if (!valid_d) check("bubble_inst", inst_d, NOP);
      if (!adv) begin
        check("stall_hold_inst", inst_d, prev_inst);
        check("stall_hold_pc", pc_d, prev_pc);
        check("stall_hold_valid", {31'd0, valid_d}, {31'd0, prev_vld});
      end else if (valid_d) begin
        if (exp_q.size() == 0) begin
          check("deliver_unexpected", pc_d, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", pc_d, e.pc);
          check("deliver_inst", inst_d, e.inst);
          delivered++;
        end
      end
      prev_inst = inst_d;
      prev_pc   = pc_d;
      prev_vld  = valid_d;
    end
  end

  task automatic run_random(input int n);
    logic [31:0] tgt;
    repeat (n) begin
      @(negedge clock);
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      if (redirect) begin
        if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF0 | ($urandom & 32'hF);
        else tgt = {8'h01, 24'($urandom)};
        redirect_pc = tgt;
        restart_stream(tgt);
      end else begin
        redirect_pc = $urandom;
        top_up();
      end
    end
    @(negedge clock);
    stall    = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_inst"}, inst_d, NOP);
    check({tag, "_pc"}, pc_d, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_d}, 32'd0);
  endtask

  initial begin
    int tries;
    restart_stream(RESET_PC);
    repeat (3) @(negedge clock);
    #1 check_reset_outputs("reset");
    @(posedge clock);
    #3 reset_n = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_PC);

    run_random(1500);

    // Reset pulse while a request is outstanding
    tries = 0;
    do begin
      @(posedge clock);
      #3;
      tries++;
    end while (!imem_req && tries < 20);
    check("midwait_req_seen", {31'd0, imem_req}, 32'd1);
    reset_n = 1'b0;
    restart_stream(RESET_PC);
    #1 check_reset_outputs("midwait_reset");
    @(posedge clock);
    #3 reset_n = 1'b1;
    #1;
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, RESET_PC);

    run_random(800);
    check("enough_deliveries", {31'd0, delivered > 100}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
